// File: rtl/piano_pkg.sv
// Shared definitions for the piano record/playback path.
package piano_pkg;

   localparam int NOTES_W        = 48;
   localparam int WORD_W         = 16;
   localparam int ADDR_W         = 7;
   localparam int WORDS_PER_BEAT = 3;
   localparam int MAX_FRAMES     = 42;
   // Base address of the last frame that fits below word 126.
   localparam int LAST_BASE      = (MAX_FRAMES - 1) * WORDS_PER_BEAT;

   localparam logic [1:0] MS_IDLE   = 2'b00;
   localparam logic [1:0] MS_RECORD = 2'b01;
   localparam logic [1:0] MS_PLAY   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARMED  = 3'd1,
      ST_FETCH  = 3'd2,
      ST_COMMIT = 3'd3,
      ST_DONE   = 3'd4
   } play_state_t;

endpackage

// File: rtl/beat_edge.sv
// Registered rising-edge detector for the tempo beat strobe.
module beat_edge (
   input  logic clk,
   input  logic reset,
   input  logic beat_i,
   output logic rise_o
);

   logic beat_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) beat_q <= 1'b0;
      else       beat_q <= beat_i;
   end

   assign rise_o = beat_i & ~beat_q;

endmodule

// File: rtl/ram_to_notes.sv
// Plays recorded 48-key frames back from RAM, one frame per beat.
// Define RAM_TO_NOTES_LOOP_EN to repeat the recording instead of stopping.
module ram_to_notes #(
   parameter int NOTES_W = 48,
   parameter int WORD_W  = 16,
   parameter int ADDR_W  = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               beat,
   input  logic [1:0]         master_state,
   input  logic [ADDR_W-1:0]  end_address,
   input  logic [WORD_W-1:0]  read_data,
   output logic [ADDR_W-1:0]  read_address,
   output logic               read_enable,
   output logic [NOTES_W-1:0] notes_out,
   output logic               playing,
   output logic               finished_playing,
   output logic [2:0]         dbg_state
);

   import piano_pkg::*;

   play_state_t        state_q, state_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [1:0]         idx_q, idx_d;
   logic [NOTES_W-1:0] shadow_q, notes_q;
   logic               fin_q, fin_d;
   logic               clear_notes, commit, rise, in_play, end_cond;
   logic [ADDR_W:0]    next_end;

   beat_edge u_beat_edge (
      .clk    (clk),
      .reset  (reset),
      .beat_i (beat),
      .rise_o (rise)
   );

   assign in_play  = (master_state == MS_PLAY);
   assign next_end = {1'b0, base_q} + (ADDR_W+1)'(WORDS_PER_BEAT);
   assign end_cond = (next_end > {1'b0, end_address}) || (base_q > ADDR_W'(LAST_BASE));

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      idx_d        = idx_q;
      fin_d        = 1'b0;
      clear_notes  = 1'b0;
      commit       = 1'b0;
      read_enable  = 1'b0;
      read_address = '0;
      if (!in_play) begin
         state_d     = ST_IDLE;
         base_d      = '0;
         idx_d       = '0;
         clear_notes = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               base_d      = '0;
               clear_notes = 1'b1;
               state_d     = ST_ARMED;
            end
            ST_ARMED: begin
               if (rise) begin
                  if (end_cond) begin
                     fin_d = 1'b1;
`ifdef RAM_TO_NOTES_LOOP_EN
                     if (end_address < ADDR_W'(WORDS_PER_BEAT)) begin
                        state_d     = ST_DONE;
                        clear_notes = 1'b1;
                     end else begin
                        base_d = '0;
                     end
`else
                     state_d     = ST_DONE;
                     clear_notes = 1'b1;
`endif
                  end else begin
                     state_d = ST_FETCH;
                     idx_d   = '0;
                  end
               end
            end
            ST_FETCH: begin
               // Fourth cycle issues no read; it only lands the last word.
               read_enable  = (idx_q != 2'd3);
               read_address = read_enable ? base_q + ADDR_W'(idx_q) : '0;
               idx_d        = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
               commit  = 1'b1;
               base_d  = base_q + ADDR_W'(WORDS_PER_BEAT);
               state_d = ST_ARMED;
            end
            default: state_d = ST_DONE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         base_q   <= '0;
         idx_q    <= '0;
         fin_q    <= 1'b0;
         shadow_q <= '0;
         notes_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         idx_q   <= idx_d;
         fin_q   <= fin_d;
         // RAM data trails the read by one cycle, so slot = idx - 1.
         if (state_q == ST_FETCH && in_play) begin
            case (idx_q)
               2'd1:    shadow_q[WORD_W-1:0]          <= read_data;
               2'd2:    shadow_q[2*WORD_W-1:WORD_W]   <= read_data;
               2'd3:    shadow_q[3*WORD_W-1:2*WORD_W] <= read_data;
               default: ;
            endcase
         end
         if (clear_notes) notes_q <= '0;
         else if (commit) notes_q <= shadow_q;
      end
   end

   assign notes_out        = notes_q;
   assign finished_playing = fin_q;
   assign playing          = (state_q == ST_ARMED) || (state_q == ST_FETCH) ||
                             (state_q == ST_COMMIT);
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_ram_to_notes.sv
// Directed bench for ram_to_notes with a behavioural one-cycle-latency RAM.
module tb_ram_to_notes;

  logic        clk = 1'b0;
  logic        reset;
  logic        beat;
  logic [1:0]  master_state;
  logic [6:0]  end_address;
  logic [15:0] read_data;
  logic [6:0]  read_address;
  logic        read_enable;
  logic [47:0] notes_out;
  logic        playing;
  logic        finished_playing;
  logic [2:0]  dbg_state;

  logic [15:0] mem [128];
  logic [6:0]  rd_log[$];
  logic [6:0]  exp_q[$];
  logic [47:0] notes_log[$];
  logic [47:0] notes_last;
  int          fin_cnt;
  int          n_vec;
  int          n_err;

  ram_to_notes dut (
    .clk              (clk),
    .reset            (reset),
    .beat             (beat),
    .master_state     (master_state),
    .end_address      (end_address),
    .read_data        (read_data),
    .read_address     (read_address),
    .read_enable      (read_enable),
    .notes_out        (notes_out),
    .playing          (playing),
    .finished_playing (finished_playing),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset / RAM ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_enable) read_data <= mem[read_address];
  end

  // Observes outputs mid-cycle and logs reads, pulses and frame changes.
  always @(negedge clk) begin
    if (read_enable) rd_log.push_back(read_address);
    if (finished_playing) fin_cnt++;
    if (notes_out !== notes_last) begin
      notes_log.push_back(notes_out);
      notes_last = notes_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beats(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
      repeat (period - 1) tick();
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    exp_q.delete();
    notes_log.delete();
    fin_cnt = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reads(input string tag);
    chk({tag, "_count"}, 64'(rd_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rd_log.size(); i++)
      chk(tag, 64'(rd_log[i]), 64'(exp_q[i]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    fin_cnt = 0;
    notes_last = '0;
    reset = 1'b1;
    beat = 1'b0;
    master_state = 2'b00;
    end_address = '0;
    read_data = '0;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    mem[0] = 16'h0F0F; mem[1] = 16'hF0F0; mem[2] = 16'hAAAA;
    mem[3] = 16'h1111; mem[4] = 16'h2222; mem[5] = 16'h3333;

    repeat (3) tick();
    chk("rst_notes", 64'(notes_out), 64'h0);
    chk("rst_rden", 64'(read_enable), 64'h0);
    chk("rst_playing", 64'(playing), 64'h0);
    chk("rst_fin", 64'(finished_playing), 64'h0);
    reset = 1'b0;
    tick();

    // end_address 0: no reads, a single finished pulse
    clear_logs();
    master_state = 2'b10;
    end_address = 7'd0;
    tick();
    chk("empty_playing", 64'(playing), 64'h1);
    run_beats(4, 6);
    chk("empty_reads", 64'(rd_log.size()), 64'h0);
    chk("empty_fin", 64'(fin_cnt), 64'h1);
    chk("empty_notes_log", 64'(notes_log.size()), 64'h0);
    chk("empty_playing_done", 64'(playing), 64'h0);
    master_state = 2'b00;
    tick();

    // single frame, cycle-exact timing
    clear_logs();
    end_address = 7'd3;
    master_state = 2'b10;
    tick();
    beat = 1'b1;
    chk("f1_c0_rden", 64'(read_enable), 64'h0);
    tick();
    beat = 1'b0;
    chk("f1_c1_rden", 64'(read_enable), 64'h1);
    chk("f1_c1_addr", 64'(read_address), 64'h0);
    tick();
    chk("f1_c2_addr", 64'(read_address), 64'h1);
    tick();
    chk("f1_c3_addr", 64'(read_address), 64'h2);
    tick();
    chk("f1_c4_rden", 64'(read_enable), 64'h0);
    chk("f1_c4_notes", 64'(notes_out), 64'h0);
    tick();
    chk("f1_c5_notes", 64'(notes_out), 64'h0);
    tick();
    chk("f1_c6_notes", 64'(notes_out), 64'hAAAAF0F00F0F);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    chk("f1_fin", 64'(finished_playing), 64'h1);
    chk("f1_end_rden", 64'(read_enable), 64'h0);
`ifdef RAM_TO_NOTES_LOOP_EN
    chk("f1_end_notes", 64'(notes_out), 64'hAAAAF0F00F0F);
    chk("f1_end_playing", 64'(playing), 64'h1);
`else
    chk("f1_end_notes", 64'(notes_out), 64'h0);
    chk("f1_end_playing", 64'(playing), 64'h0);
`endif
    tick();
    chk("f1_fin_once", 64'(finished_playing), 64'h0);
    master_state = 2'b00;
    tick();

    // two frames, beat every 5 clocks: alternate beats dropped
    clear_logs();
    end_address = 7'd6;
    master_state = 2'b10;
    tick();
    run_beats(5, 5);
    repeat (3) tick();
    for (int i = 0; i < 6; i++) exp_q.push_back(7'(i));
    chk_reads("two_addr");
    chk("two_fin", 64'(fin_cnt), 64'h1);
    chk("two_frame0", 64'(notes_log.size() > 0 ? notes_log[0] : 48'h0), 64'hAAAAF0F00F0F);
    chk("two_frame1", 64'(notes_log.size() > 1 ? notes_log[1] : 48'h0), 64'h333322221111);
`ifndef RAM_TO_NOTES_LOOP_EN
    chk("two_clear", 64'(notes_log.size()), 64'h3);
`endif
    master_state = 2'b00;
    tick();

    // leave PLAY during FETCH, then restart from address 0
    clear_logs();
    master_state = 2'b10;
    tick();
    run_beats(1, 7);
    chk("abort_pre_notes", 64'(notes_out), 64'hAAAAF0F00F0F);
    beat = 1'b1;
    tick();
    beat = 1'b0;
    tick();
    master_state = 2'b00;
    tick();
    chk("abort_notes", 64'(notes_out), 64'h0);
    chk("abort_rden", 64'(read_enable), 64'h0);
    chk("abort_playing", 64'(playing), 64'h0);
    chk("abort_fin", 64'(fin_cnt), 64'h0);
    master_state = 2'b10;
    tick();
    beat = 1'b1;
    tick();
    beat = 1'b0;
    chk("restart_rden", 64'(read_enable), 64'h1);
    chk("restart_addr", 64'(read_address), 64'h0);
    repeat (6) tick();
    master_state = 2'b00;
    tick();

    // full-size recording: 42 frames, never past word 125
    clear_logs();
    for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i);
    end_address = 7'd127;
    master_state = 2'b10;
    tick();
    run_beats(42, 6);
    chk("full_last_notes", 64'(notes_out), 64'h107D107C107B);
    run_beats(1, 6);
    chk("full_reads", 64'(rd_log.size()), 64'd126);
    chk("full_last_addr", 64'(rd_log.size() > 0 ? rd_log[rd_log.size()-1] : 7'h0), 64'd125);
    chk("full_fin", 64'(fin_cnt), 64'h1);
    master_state = 2'b00;
    tick();

`ifdef RAM_TO_NOTES_LOOP_EN
    // looping playback: two passes with a pulse after each
    clear_logs();
    end_address = 7'd6;
    master_state = 2'b10;
    tick();
    run_beats(6, 6);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 6; i++) exp_q.push_back(7'(i));
    chk_reads("loop_addr");
    chk("loop_fin", 64'(fin_cnt), 64'h2);
    master_state = 2'b00;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
